fifo_uart_tx: RTL and testbench

//   Read-side consumer for the 32-bit fifo: pops words with single-cycle read

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pops 32-bit words from the fifo and sends them as UART frames, least-significant byte first.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit to each frame (8E1 instead of 8N1).
module fifo_uart_tx #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int POLL_GAP     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             fifo_read,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int BYTES   = WIDTH / 8;
    localparam int CNT_MAX = (CLKS_PER_BIT > POLL_GAP) ? CLKS_PER_BIT : POLL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_POLL   = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd7;
`endif

    logic [2:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [2:0]        bitIdx_q,    bitIdx_d;
    logic [BIDX_W-1:0] byteIdx_q,   byteIdx_d;
    logic [WIDTH-1:0]  shift_q,     shift_d;
    logic [15:0]       wordsSent_q, wordsSent_d;

    logic       baudDone;
    logic [7:0] curByte;

    // The same counter times both bit periods and the poll gap; the states never overlap.
    assign baudDone = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign curByte  = shift_q[7:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitIdx_d    = bitIdx_q;
        byteIdx_d   = byteIdx_q;
        shift_d     = shift_q;
        wordsSent_d = wordsSent_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                cnt_d = '0;
                // All ones is the fifo's empty-read value, so such a word cannot be sent.
                if (fifo_data == {WIDTH{1'b1}}) begin
                    state_d = S_POLL;
                end else begin
                    shift_d   = fifo_data;
                    byteIdx_d = '0;
                    state_d   = S_START;
                end
            end
            S_POLL: begin
                if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                if (baudDone) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baudDone) begin
                    cnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baudDone) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baudDone) begin
                    cnt_d = '0;
                    if (byteIdx_q == BIDX_W'(BYTES - 1)) begin
                        wordsSent_d = wordsSent_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        byteIdx_d = byteIdx_q + BIDX_W'(1);
                        shift_d   = shift_q >> 8;
                        state_d   = S_START;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            byteIdx_q   <= '0;
            shift_q     <= '0;
            wordsSent_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            byteIdx_q   <= byteIdx_d;
            shift_q     <= shift_d;
            wordsSent_q <= wordsSent_d;
        end
    end

    // Outputs decode the state register directly so reset forces the line idle at once.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = curByte[bitIdx_q];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx = ^curByte;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign fifo_read  = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE) && (state_q != S_POLL);
    assign words_sent = wordsSent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-based fifo model feeds the DUT and a
// UART receiver decodes the tx line and compares the bytes against what was popped.
module tb_fifo_uart_tx;

    localparam int W     = 32;
    localparam int CPB   = 4;
    localparam int GAP   = 2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int BYTE_CYC = FRAME * CPB;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         fifo_read;
    logic [W-1:0] fifo_data;
    logic         tx;
    logic         busy;
    logic [15:0]  words_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] fifoQ[$];
    logic [7:0]   expBytes[$];
    int           readTimes[$];
    int           startTimes[$];
    int           expWords = 0;
    int           rxCount  = 0;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .POLL_GAP(GAP)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fifo_read(fifo_read),
        .fifo_data(fifo_data),
        .tx(tx),
        .busy(busy),
        .words_sent(words_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitWords(input logic [15:0] target, input int budget, input string tag);
        int n = 0;
        while (words_sent !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {16'h0, words_sent}, {16'h0, target});
    endtask

    task automatic checkSpacing(input string tag, input int gapAt);
        for (int i = 1; i < startTimes.size(); i++) begin
            checkOutput(tag, startTimes[i] - startTimes[i-1],
                        (i == gapAt) ? BYTE_CYC + 3 : BYTE_CYC);
        end
    endtask

    // Fifo model: a pop is served on the cycle after the read pulse; at other times the
    // data bus carries junk the DUT must ignore.
    initial begin
        logic         prevRead;
        logic [W-1:0] w;
        prevRead = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && fifo_read === 1'b1) begin
                readTimes.push_back(cyc);
                if (fifoQ.size() > 0) begin
                    w = fifoQ.pop_front();
                    if (w != {W{1'b1}}) begin
                        for (int b = 0; b < W / 8; b++) expBytes.push_back(w[8*b +: 8]);
                        expWords++;
                    end
                end else begin
                    w = {W{1'b1}};
                end
                fifo_data = w;
                prevRead  = 1'b1;
            end else begin
                if (!prevRead) fifo_data = $urandom();
                prevRead = 1'b0;
            end
        end
    end

    // UART receiver sampling each bit in the second cycle of its period.
    initial begin
        logic       rxActive;
        int         rxPos;
        int         k;
        logic [7:0] rxByte;
        rxActive = 1'b0;
        rxPos    = 0;
        rxByte   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rxActive = 1'b0;
            end else if (!rxActive) begin
                if (tx === 1'b0) begin
                    rxActive = 1'b1;
                    rxPos    = 0;
                    startTimes.push_back(cyc);
                end
            end else begin
                rxPos++;
                if (rxPos % CPB == 1) begin
                    k = rxPos / CPB;
                    if (k == 0) begin
                        checkOutput("rx_start_bit", {31'h0, tx}, 32'h0);
                    end else if (k <= 8) begin
                        rxByte[k-1] = tx;
`ifdef FIFO_UART_TX_PARITY_EN
                    end else if (k == 9) begin
                        checkOutput("rx_parity", {31'h0, tx}, {31'h0, ^rxByte});
`endif
                    end else begin
                        checkOutput("rx_stop_bit", {31'h0, tx}, 32'h1);
                        checkOutput("rx_byte_expected", {31'h0, expBytes.size() > 0}, 32'h1);
                        if (expBytes.size() > 0) begin
                            checkOutput("rx_byte", {24'h0, rxByte}, {24'h0, expBytes.pop_front()});
                        end
                        rxCount++;
                        rxActive = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic txLow;
        int   base;
        int   n;
        int   target;
        logic [W-1:0] w;

        reset     = 1'b1;
        enable    = 1'b0;
        fifo_data = {W{1'b1}};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_tx", {31'h0, tx}, 32'h1);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_read", {31'h0, fifo_read}, 32'h0);
        checkOutput("reset_words", {16'h0, words_sent}, 32'h0);

        // Reset in the middle of a data bit that is driving the line low.
        fifoQ.push_back({24'($urandom()), 8'h00});
        enable = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("pre_reset_busy", {31'h0, busy}, 32'h1);
        checkOutput("pre_reset_tx", {31'h0, tx}, 32'h0);
        #1 reset = 1'b1;
        #1;
        checkOutput("midframe_reset_tx", {31'h0, tx}, 32'h1);
        checkOutput("midframe_reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("midframe_reset_read", {31'h0, fifo_read}, 32'h0);
        checkOutput("midframe_reset_words", {16'h0, words_sent}, 32'h0);
        enable = 1'b0;
        expBytes.delete();
        expWords = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single word 0x000000A5.
        readTimes.delete();
        startTimes.delete();
        fifoQ.push_back(32'h0000_00A5);
        enable = 1'b1;
        waitWords(16'd1, 600, "single_word_count");
        enable = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("single_word_reads", readTimes.size(), 32'd1);
        checkOutput("single_word_bytes", startTimes.size(), 32'd4);
        checkSpacing("single_word_spacing", -1);
        checkOutput("single_word_drained", expBytes.size(), 32'd0);

        // Empty fifo: polling only.
        readTimes.delete();
        startTimes.delete();
        txLow  = 1'b0;
        enable = 1'b1;
        repeat (23) begin
            @(negedge clk);
            if (tx !== 1'b1) txLow = 1'b1;
        end
        enable = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("poll_tx_idle", {31'h0, txLow}, 32'h0);
        checkOutput("poll_read_count", readTimes.size(), 32'd5);
        for (int i = 1; i < readTimes.size(); i++) begin
            checkOutput("poll_read_period", readTimes[i] - readTimes[i-1], 32'd5);
        end
        checkOutput("poll_words", {16'h0, words_sent}, 32'd1);

        // Two back-to-back words.
        startTimes.delete();
        fifoQ.push_back(32'h1122_3344);
        fifoQ.push_back(32'h5566_7788);
        enable = 1'b1;
        waitWords(16'd3, 1200, "two_words_count");
        enable = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("two_words_bytes", startTimes.size(), 32'd8);
        checkSpacing("two_words_spacing", 4);
        checkOutput("two_words_drained", expBytes.size(), 32'd0);

        // enable dropped during the second byte.
        readTimes.delete();
        base = rxCount;
        fifoQ.push_back(32'hDEAD_BEEF);
        enable = 1'b1;
        n = 0;
        while (rxCount <= base && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drop_first_byte_seen", {31'h0, rxCount > base}, 32'h1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        waitWords(16'd4, 600, "drop_word_completes");
        repeat (30) @(negedge clk);
        checkOutput("drop_reads", readTimes.size(), 32'd1);
        checkOutput("drop_idle_busy", {31'h0, busy}, 32'h0);
        checkOutput("drop_bytes", rxCount - base, 32'd4);
        checkOutput("drop_drained", expBytes.size(), 32'd0);

        // Random words with an embedded all-ones word that must be dropped.
        target = 4;
        fifoQ.push_back(32'h0000_0307);
        target++;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                w = {W{1'b1}};
            end else begin
                w = $urandom();
                if (w == {W{1'b1}}) w = 32'h0;
                target++;
            end
            fifoQ.push_back(w);
        end
        enable = 1'b1;
        waitWords(16'(target), 4000, "random_words_count");
        enable = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("random_fifo_empty", fifoQ.size(), 32'd0);
        checkOutput("random_drained", expBytes.size(), 32'd0);
        checkOutput("random_model_words", expWords, 32'(target));
        checkOutput("final_busy", {31'h0, busy}, 32'h0);
        checkOutput("final_tx", {31'h0, tx}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
